// File: rtl/vga_screen_mux_if.sv
// Bus between the per-screen draw pipelines and the screen selector:
// flattened source streams and the game-state select go in, the chosen VGA stream comes out.
interface vga_screen_mux_if #(
    parameter int N_SRC = 4,
    parameter int HC_W  = 11,
    parameter int RGB_W = 12
);
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [SEL_W-1:0]       sel;
    logic [N_SRC*HC_W-1:0]  src_hcount;
    logic [N_SRC*HC_W-1:0]  src_vcount;
    logic [N_SRC-1:0]       src_hsync;
    logic [N_SRC-1:0]       src_vsync;
    logic [N_SRC-1:0]       src_hblnk;
    logic [N_SRC-1:0]       src_vblnk;
    logic [N_SRC*RGB_W-1:0] src_rgb;

    logic [HC_W-1:0]        hcount;
    logic [HC_W-1:0]        vcount;
    logic                   hsync;
    logic                   vsync;
    logic                   hblnk;
    logic                   vblnk;
    logic [RGB_W-1:0]       rgb;
    logic [SEL_W-1:0]       active_src;
    logic                   busy;

    modport master (
        output sel, src_hcount, src_vcount, src_hsync, src_vsync, src_hblnk, src_vblnk, src_rgb,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb, active_src, busy
    );

    modport slave (
        input  sel, src_hcount, src_vcount, src_hsync, src_vsync, src_hblnk, src_vblnk, src_rgb,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb, active_src, busy
    );
endinterface

// File: rtl/vga_screen_mux.sv
// Frame-synchronous VGA source selector: swaps streams only at the rising edge of vblank
// of the stream on screen, optionally inserting black frames so no torn frame is ever shown.
module vga_screen_mux #(
    parameter int N_SRC       = 4,
    parameter int HC_W        = 11,
    parameter int RGB_W       = 12,
    parameter int FADE_FRAMES = 1,
    parameter int DEFAULT_SRC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    vga_screen_mux_if.slave bus
);
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = (FADE_FRAMES > 0) ? $clog2(FADE_FRAMES + 1) : 1;
    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SRC);
    localparam logic [CNT_W-1:0] FADE_LD = CNT_W'(FADE_FRAMES);

    typedef enum logic [1:0] {
        SHOW    = 2'd0,
        PENDING = 2'd1,
        BLANK   = 2'd2
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] active_src;
    logic [SEL_W-1:0] target;
    logic [CNT_W-1:0] cnt;
    logic             vblnk_d;
    logic             sel_ok;
    logic             fb;

    logic [HC_W-1:0]  mux_hcount;
    logic [HC_W-1:0]  mux_vcount;
    logic             mux_hsync;
    logic             mux_vsync;
    logic             mux_hblnk;
    logic             mux_vblnk;
    logic [RGB_W-1:0] mux_rgb;

    logic [HC_W-1:0]  out_hcount;
    logic [HC_W-1:0]  out_vcount;
    logic             out_hsync;
    logic             out_vsync;
    logic             out_hblnk;
    logic             out_vblnk;
    logic [RGB_W-1:0] out_rgb;

    // Out-of-range requests (possible when N_SRC is not a power of two) leave the target alone.
    assign sel_ok = ({1'b0, bus.sel} < N_SRC[SEL_W:0]);

    always_comb begin
        mux_hcount = '0;
        mux_vcount = '0;
        mux_hsync  = 1'b0;
        mux_vsync  = 1'b0;
        mux_hblnk  = 1'b0;
        mux_vblnk  = 1'b0;
        mux_rgb    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (active_src == SEL_W'(i)) begin
                mux_hcount = bus.src_hcount[i*HC_W +: HC_W];
                mux_vcount = bus.src_vcount[i*HC_W +: HC_W];
                mux_hsync  = bus.src_hsync[i];
                mux_vsync  = bus.src_vsync[i];
                mux_hblnk  = bus.src_hblnk[i];
                mux_vblnk  = bus.src_vblnk[i];
                mux_rgb    = bus.src_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    // Frame boundary is judged on the stream currently on screen, not the requested one.
    assign fb = mux_vblnk & ~vblnk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SHOW;
            active_src <= DEF_SEL;
            target     <= DEF_SEL;
            cnt        <= '0;
            vblnk_d    <= 1'b0;
        end else begin
            vblnk_d <= mux_vblnk;
            if (sel_ok) begin
                target <= bus.sel;
            end
            case (state)
                SHOW: begin
                    if (target != active_src) begin
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (target == active_src) begin
                        state <= SHOW;
                    end else if (fb) begin
                        active_src <= target;
                        if (FADE_FRAMES == 0) begin
                            state <= SHOW;
                        end else begin
                            cnt   <= FADE_LD;
                            state <= BLANK;
                        end
                    end
                end
                BLANK: begin
                    // A new request during the fade restarts the black period on the new stream.
                    if (fb) begin
                        if (target != active_src) begin
                            active_src <= target;
                            cnt        <= FADE_LD;
                        end else if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                            if (cnt == CNT_W'(1)) begin
                                state <= SHOW;
                            end
                        end
                    end
                end
                default: begin
                    state <= SHOW;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hcount <= '0;
            out_vcount <= '0;
            out_hsync  <= 1'b0;
            out_vsync  <= 1'b0;
            out_hblnk  <= 1'b0;
            out_vblnk  <= 1'b0;
            out_rgb    <= '0;
        end else begin
            out_hcount <= mux_hcount;
            out_vcount <= mux_vcount;
            out_hsync  <= mux_hsync;
            out_vsync  <= mux_vsync;
            out_hblnk  <= mux_hblnk;
            out_vblnk  <= mux_vblnk;
            out_rgb    <= (state == BLANK) ? '0 : mux_rgb;
        end
    end

    assign bus.hcount     = out_hcount;
    assign bus.vcount     = out_vcount;
    assign bus.hsync      = out_hsync;
    assign bus.vsync      = out_vsync;
    assign bus.hblnk      = out_hblnk;
    assign bus.vblnk      = out_vblnk;
    assign bus.rgb        = out_rgb;
    assign bus.active_src = active_src;
    assign bus.busy       = (state != SHOW);
endmodule
